// File: rtl/usrt_pkg.sv
// Shared definitions for the APB USRT peripheral: register map, register bit
// positions and the serial FSM state encodings.
package usrt_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_DIV    = 2'd3;

    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_RX_FULL   = 2;
    localparam int ST_RX_EMPTY  = 3;
    localparam int ST_OVERRUN   = 4;
    localparam int ST_PARITY    = 5;
    localparam int ST_FRAME     = 6;
    localparam int ST_TX_BUSY   = 7;

    localparam int CTRL_TX_EN   = 0;
    localparam int CTRL_RX_EN   = 1;
    localparam int CTRL_PAR_EN  = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/usrt_fifo.sv
// Synchronous show-ahead FIFO. A push into a full FIFO is accepted only when a
// pop happens on the same edge; a pop from an empty FIFO is ignored.
module usrt_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/apb_usrt_ctrl.sv
// APB slave USRT: register file, baud generator, TX and RX frame FSMs.
//   TX state  | meaning               RX state  | meaning
//   TX_IDLE   | line idle (Rx=1)      RX_IDLE   | waiting for start bit
//   TX_START  | driving start bit     RX_DATA   | sampling data bits
//   TX_DATA   | driving data bits     RX_PARITY | sampling parity bit
//   TX_PARITY | driving parity bit    RX_STOP   | sampling stop bit, push word
//   TX_STOP   | driving stop bit
module apb_usrt_ctrl
    import usrt_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       pClk,
    input  logic       pReset,
    input  logic       pSelect,
    input  logic       pEnable,
    input  logic       pWrite,
    input  logic [1:0] pAddress,
    input  logic [7:0] pWData,
    output logic [7:0] pRData,
    output logic       pReady,
    output logic       pSlvErr,
    output logic       uClk,
    output logic       Rx,
    input  logic       Tx
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

    logic              access, wr_acc, rd_acc;
    logic [2:0]        ctrl_q;
    logic [7:0]        div_q, div_act, baud_cnt;
    logic              uclk_q, wrap, fall_tick, rise_tick;
    logic              overrun_q, par_err_q, frm_err_q;
    logic              w1c;

    logic              tx_push, tx_pop, tx_full, tx_empty;
    logic [DATA_W-1:0] tx_rdata, tx_sh;
    logic [2:0]        tx_cnt;
    logic              tx_par_q, tx_par_bit, tx_start_ok, tx_busy;
    tx_state_t         tx_state, tx_next;

    logic              rx_push, rx_pop, rx_full, rx_empty;
    logic [DATA_W-1:0] rx_rdata, rx_sh;
    logic [2:0]        rx_cnt;
    logic              rx_par_q, rx_par_bit;
    logic              perr_set, ferr_set, overrun_set;
    rx_state_t         rx_state, rx_next;

    logic [7:0]        status, rx_word;

    assign access = pSelect && pEnable;
    assign wr_acc = access && pWrite;
    assign rd_acc = access && !pWrite;
    assign w1c    = wr_acc && (pAddress == ADDR_STATUS);
    assign pReady = 1'b1;
    assign uClk   = uclk_q;

    // A new divisor only takes effect at a wrap so the current half-period is never cut short.
    assign wrap      = (baud_cnt == div_act);
    assign fall_tick = wrap && uclk_q;
    assign rise_tick = wrap && !uclk_q;

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            baud_cnt <= '0;
            uclk_q   <= 1'b0;
            div_act  <= '0;
        end else if (wrap) begin
            baud_cnt <= '0;
            uclk_q   <= !uclk_q;
            div_act  <= div_q;
        end else begin
            baud_cnt <= baud_cnt + 8'd1;
        end
    end

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            ctrl_q    <= '0;
            div_q     <= '0;
            overrun_q <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            if (wr_acc && pAddress == ADDR_CTRL) ctrl_q <= pWData[2:0];
            if (wr_acc && pAddress == ADDR_DIV)  div_q  <= pWData;
            overrun_q <= (overrun_q && !(w1c && pWData[ST_OVERRUN])) || overrun_set;
            par_err_q <= (par_err_q && !(w1c && pWData[ST_PARITY]))  || perr_set;
            frm_err_q <= (frm_err_q && !(w1c && pWData[ST_FRAME]))   || ferr_set;
        end
    end

    assign tx_push = wr_acc && (pAddress == ADDR_DATA);
    assign rx_pop  = rd_acc && (pAddress == ADDR_DATA) && !rx_empty;

    usrt_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (pClk),
        .rst_n (pReset),
        .push  (tx_push),
        .wdata (pWData[DATA_W-1:0]),
        .pop   (tx_pop),
        .rdata (tx_rdata),
        .full  (tx_full),
        .empty (tx_empty)
    );

    usrt_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (pClk),
        .rst_n (pReset),
        .push  (rx_push),
        .wdata (rx_sh),
        .pop   (rx_pop),
        .rdata (rx_rdata),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign tx_start_ok = ctrl_q[CTRL_TX_EN] && !tx_empty;

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) tx_state <= TX_IDLE;
        else         tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        if (fall_tick) begin
            case (tx_state)
                TX_IDLE:   if (tx_start_ok) tx_next = TX_START;
                TX_START:  tx_next = TX_DATA;
                TX_DATA:   if (tx_cnt == LAST_BIT) tx_next = tx_par_q ? TX_PARITY : TX_STOP;
                TX_PARITY: tx_next = TX_STOP;
                TX_STOP:   tx_next = tx_start_ok ? TX_START : TX_IDLE;
                default:   tx_next = TX_IDLE;
            endcase
        end
    end

    // Rx is decoded from state so reset forces the line idle without waiting for a clock.
    always_comb begin
        tx_pop  = fall_tick && tx_start_ok && (tx_state == TX_IDLE || tx_state == TX_STOP);
        tx_busy = (tx_state != TX_IDLE);
        case (tx_state)
            TX_START:  Rx = 1'b0;
            TX_DATA:   Rx = tx_sh[0];
            TX_PARITY: Rx = tx_par_bit;
            default:   Rx = 1'b1;
        endcase
    end

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            tx_sh      <= '0;
            tx_cnt     <= '0;
            tx_par_q   <= 1'b0;
            tx_par_bit <= 1'b0;
        end else if (tx_pop) begin
            tx_sh      <= tx_rdata;
            tx_cnt     <= '0;
            tx_par_q   <= ctrl_q[CTRL_PAR_EN];
            tx_par_bit <= ^tx_rdata;
        end else if (fall_tick && tx_state == TX_DATA) begin
            tx_sh  <= tx_sh >> 1;
            tx_cnt <= tx_cnt + 3'd1;
        end
    end

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) rx_state <= RX_IDLE;
        else         rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        if (rise_tick) begin
            case (rx_state)
                RX_IDLE:   if (ctrl_q[CTRL_RX_EN] && !Tx) rx_next = RX_DATA;
                RX_DATA:   if (rx_cnt == LAST_BIT) rx_next = rx_par_q ? RX_PARITY : RX_STOP;
                RX_PARITY: rx_next = RX_STOP;
                RX_STOP:   rx_next = RX_IDLE;
                default:   rx_next = RX_IDLE;
            endcase
        end
    end

    // A full FIFO still accepts the word when software pops on the same edge.
    always_comb begin
        rx_push     = rise_tick && (rx_state == RX_STOP);
        perr_set    = rx_push && rx_par_q && (rx_par_bit != ^rx_sh);
        ferr_set    = rx_push && !Tx;
        overrun_set = rx_push && rx_full && !rx_pop;
    end

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            rx_sh      <= '0;
            rx_cnt     <= '0;
            rx_par_q   <= 1'b0;
            rx_par_bit <= 1'b0;
        end else if (rise_tick) begin
            case (rx_state)
                RX_IDLE: begin
                    if (ctrl_q[CTRL_RX_EN] && !Tx) begin
                        rx_cnt   <= '0;
                        rx_par_q <= ctrl_q[CTRL_PAR_EN];
                    end
                end
                RX_DATA: begin
                    rx_sh  <= {Tx, rx_sh[DATA_W-1:1]};
                    rx_cnt <= rx_cnt + 3'd1;
                end
                RX_PARITY: rx_par_bit <= Tx;
                default: ;
            endcase
        end
    end

    always_comb begin
        status              = '0;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_OVERRUN]  = overrun_q;
        status[ST_PARITY]   = par_err_q;
        status[ST_FRAME]    = frm_err_q;
        status[ST_TX_BUSY]  = tx_busy;
        rx_word             = '0;
        rx_word[DATA_W-1:0] = rx_rdata;
    end

    always_comb begin
        pRData  = '0;
        pSlvErr = 1'b0;
        if (rd_acc) begin
            case (pAddress)
                ADDR_DATA: begin
                    if (rx_empty) pSlvErr = 1'b1;
                    else          pRData  = rx_word;
                end
                ADDR_STATUS: pRData = status;
                ADDR_CTRL:   pRData = {5'b0, ctrl_q};
                default:     pRData = div_q;
            endcase
        end
        if (wr_acc && pAddress == ADDR_DATA && tx_full && !tx_pop) pSlvErr = 1'b1;
    end

endmodule

// File: tb/tb_apb_usrt_ctrl.sv
// Directed bench for apb_usrt_ctrl: APB register traffic, serial frame capture
// on Rx, injected frames on Tx and an Rx-to-Tx loopback.
module tb_apb_usrt_ctrl;

    logic       pClk = 1'b0;
    logic       pReset;
    logic       pSelect, pEnable, pWrite;
    logic [1:0] pAddress;
    logic [7:0] pWData;
    logic [7:0] pRData;
    logic       pReady, pSlvErr, uClk, Rx, Tx;
    logic       loop_en, tx_drv;

    int n_checks = 0;
    int n_fail   = 0;

    assign Tx = loop_en ? Rx : tx_drv;

    always #5 pClk = ~pClk;

    apb_usrt_ctrl #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
        .pClk     (pClk),
        .pReset   (pReset),
        .pSelect  (pSelect),
        .pEnable  (pEnable),
        .pWrite   (pWrite),
        .pAddress (pAddress),
        .pWData   (pWData),
        .pRData   (pRData),
        .pReady   (pReady),
        .pSlvErr  (pSlvErr),
        .uClk     (uClk),
        .Rx       (Rx),
        .Tx       (Tx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [1:0] a, input logic [7:0] d, output logic err);
        @(posedge pClk); #1;
        pSelect = 1'b1; pEnable = 1'b0; pWrite = 1'b1; pAddress = a; pWData = d;
        @(posedge pClk); #1;
        pEnable = 1'b1;
        #3;
        err = pSlvErr;
        @(posedge pClk); #1;
        pSelect = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
    endtask

    task automatic apb_read(input logic [1:0] a, output logic [7:0] d, output logic err);
        @(posedge pClk); #1;
        pSelect = 1'b1; pEnable = 1'b0; pWrite = 1'b0; pAddress = a;
        @(posedge pClk); #1;
        pEnable = 1'b1;
        #3;
        d   = pRData;
        err = pSlvErr;
        @(posedge pClk); #1;
        pSelect = 1'b0; pEnable = 1'b0;
    endtask

    // Waits (bounded) for a start bit on a fall tick, then records the following bits.
    task automatic capture_frame(input int nbits, output logic [15:0] bits,
                                 output longint t0, output longint tl, output logic found);
        found = 1'b0;
        bits  = '0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge uClk); #1;
            if (Rx === 1'b0) found = 1'b1;
        end
        t0 = $time;
        if (found) begin
            for (int k = 1; k < nbits; k++) begin
                @(negedge uClk); #1;
                bits[k] = Rx;
            end
        end
        tl = $time;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic use_par,
                              input logic par, input logic stop);
        @(negedge uClk); #1; tx_drv = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge uClk); #1; tx_drv = d[k];
        end
        if (use_par) begin
            @(negedge uClk); #1; tx_drv = par;
        end
        @(negedge uClk); #1; tx_drv = stop;
        @(negedge uClk); #1; tx_drv = 1'b1;
    endtask

    logic [7:0]  rd;
    logic        err, found;
    logic [15:0] bits;
    longint      t0, tl, tprev;
    logic        errs [5];
    logic [7:0]  words [4];
    int          zeros;

    initial begin
        pReset = 1'b0; pSelect = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
        pAddress = '0; pWData = '0; loop_en = 1'b0; tx_drv = 1'b1;

        // Reset values
        repeat (3) @(posedge pClk);
        #2;
        check("rst_prdata",  pRData,  8'h00);
        check("rst_pslverr", pSlvErr, 1'b0);
        check("rst_pready",  pReady,  1'b1);
        check("rst_uclk",    uClk,    1'b0);
        check("rst_rx",      Rx,      1'b1);
        pReset = 1'b1;
        apb_read(ADDR_C(), rd, err);
        check("rst_ctrl", rd, 8'h00);
        apb_read(2'd3, rd, err);
        check("rst_div", rd, 8'h00);
        apb_read(2'd1, rd, err);
        check("rst_status", rd, 8'h0A);

        // Plain frame 0xA5 at DIV=1
        apb_write(2'd2, 8'h01, err);
        apb_write(2'd3, 8'h01, err);
        fork
            apb_write(2'd0, 8'hA5, err);
            capture_frame(10, bits, t0, tl, found);
        join
        check("a5_start_found", found, 1'b1);
        check("a5_bits", bits, 16'h034A);
        check("a5_len", 32'(tl - t0), 32'd360);
        check("a5_wr_err", err, 1'b0);
        @(negedge uClk); #1;
        check("a5_idle_after", Rx, 1'b1);
        apb_read(2'd1, rd, err);
        check("a5_status_idle", rd, 8'h0A);

        // Parity frame 0x07: three ones -> parity bit 1
        apb_write(2'd2, 8'h05, err);
        fork
            apb_write(2'd0, 8'h07, err);
            capture_frame(11, bits, t0, tl, found);
        join
        check("par_start_found", found, 1'b1);
        check("par_bits", bits, 16'h060E);
        check("par_len", 32'(tl - t0), 32'd400);

        // Loopback with parity
        loop_en = 1'b1;
        apb_write(2'd2, 8'h07, err);
        apb_write(2'd0, 8'h3C, err);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            apb_read(2'd1, rd, err);
            if (rd[3] == 1'b0) found = 1'b1;
        end
        check("loop_rx_arrived", found, 1'b1);
        apb_read(2'd0, rd, err);
        check("loop_data", rd, 8'h3C);
        check("loop_err", err, 1'b0);
        repeat (20) @(posedge pClk);
        apb_read(2'd1, rd, err);
        check("loop_status", rd, 8'h0A);
        apb_write(2'd2, 8'h00, err);
        loop_en = 1'b0;

        // TX FIFO overfill with tx disabled, then drain
        apb_write(2'd0, 8'h11, errs[0]);
        apb_write(2'd0, 8'h22, errs[1]);
        apb_write(2'd0, 8'h33, errs[2]);
        apb_write(2'd0, 8'h44, errs[3]);
        apb_write(2'd0, 8'h55, errs[4]);
        check("fill_err_4th", errs[3], 1'b0);
        check("fill_err_5th", errs[4], 1'b1);
        apb_read(2'd1, rd, err);
        check("fill_status", rd, 8'h09);
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
        fork
            apb_write(2'd2, 8'h01, err);
            capture_frame(10, bits, t0, tl, found);
        join
        check("drain0_found", found, 1'b1);
        check("drain0_bits", bits, {6'b0, 1'b1, words[0], 1'b0});
        for (int f = 1; f < 4; f++) begin
            tprev = t0;
            capture_frame(10, bits, t0, tl, found);
            check("drainN_found", found, 1'b1);
            check("drainN_bits", bits, {6'b0, 1'b1, words[f], 1'b0});
            check("drainN_gap", 32'(t0 - tprev), 32'd400);
        end
        zeros = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge uClk); #1;
            if (Rx !== 1'b1) zeros++;
        end
        check("drain_no_5th", zeros, 0);

        // RX overrun: five frames into a four-deep FIFO
        apb_write(2'd2, 8'h02, err);
        for (int f = 1; f <= 5; f++) send_frame(8'(f), 1'b0, 1'b0, 1'b1);
        apb_read(2'd1, rd, err);
        check("ovr_status", rd, 8'h16);
        for (int f = 1; f <= 4; f++) begin
            apb_read(2'd0, rd, err);
            check("ovr_word", rd, 32'(f));
            check("ovr_word_err", err, 1'b0);
        end
        apb_read(2'd1, rd, err);
        check("ovr_status_drained", rd, 8'h1A);
        apb_write(2'd1, 8'h10, err);
        apb_read(2'd1, rd, err);
        check("ovr_cleared", rd, 8'h0A);

        // Parity and framing errors
        apb_write(2'd2, 8'h06, err);
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        send_frame(8'h08, 1'b1, 1'b1, 1'b0);
        apb_read(2'd1, rd, err);
        check("errs_status", rd, 8'h62);
        apb_read(2'd0, rd, err);
        check("errs_word0", rd, 8'h03);
        apb_read(2'd0, rd, err);
        check("errs_word1", rd, 8'h08);
        apb_read(2'd0, rd, err);
        check("empty_read_data", rd, 8'h00);
        check("empty_read_err", err, 1'b1);
        apb_write(2'd1, 8'h60, err);
        apb_read(2'd1, rd, err);
        check("errs_cleared", rd, 8'h0A);

        // Reset mid-frame returns the line to idle immediately
        apb_write(2'd2, 8'h01, err);
        fork
            apb_write(2'd0, 8'h00, err);
            capture_frame(3, bits, t0, tl, found);
        join
        check("midrst_frame_seen", found, 1'b1);
        check("midrst_rx_low", Rx, 1'b0);
        @(negedge pClk);
        pReset = 1'b0;
        #1;
        check("midrst_rx", Rx, 1'b1);
        check("midrst_uclk", uClk, 1'b0);
        #20;
        pReset = 1'b1;
        apb_read(2'd2, rd, err);
        check("midrst_ctrl", rd, 8'h00);
        apb_read(2'd1, rd, err);
        check("midrst_status", rd, 8'h0A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    function automatic logic [1:0] ADDR_C();
        return 2'd2;
    endfunction

endmodule

// File: doc/apb_usrt_ctrl.md
# apb_usrt_ctrl

Parametrised APB-slave USRT peripheral: the successor to the fixed 8-bit single-register APB/USRT top level. Adds configurable data width and FIFO depth, a programmable baud divisor, optional even parity, status/error reporting and APB wait/error signalling. Sits on the APB bus as one slave; drives the synchronous serial link (bit clock plus data) to the off-chip USRT partner.

## Interface
- DATA_W, 8: serial data bits per frame (5..8); APB data bus stays 8 bits, unused high bits read 0.
- FIFO_DEPTH, 4: entries in each of the TX and RX FIFOs; power of two, ≥2.
- pClk  in  1  system/APB clock; the only clock.
- pReset  in  1  asynchronous, active-low reset.
- pSelect  in  1  APB select.
- pEnable  in  1  APB access phase.
- pWrite  in  1  1 = write, 0 = read.
- pAddress  in  2  register address.
- pWData  in  8  write data.
- pRData  out  8  read data, valid in access phase.
- pReady  out  1  tied 1 (zero wait states).
- pSlvErr  out  1  error response, valid in access phase.
- uClk  out  1  USRT bit clock.
- Rx  out  1  serial data to partner (idle 1).
- Tx  in  1  serial data from partner (already synchronous to uClk).

## Operation
- Registers: 0 DATA (write pushes TX FIFO; read pops RX FIFO); 1 STATUS (RO except W1C bits); 2 CTRL [0]=tx_en, [1]=rx_en, [2]=par_en; 3 DIV (8 bits).
- STATUS: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] overrun (W1C), [5] parity_err (W1C), [6] frame_err (W1C), [7] tx_busy.
- Access completes when pSelect & pEnable; FIFO push/pop occurs on that pClk edge.
- DATA write with TX FIFO full: data dropped, pSlvErr=1. DATA read with RX FIFO empty: pRData=0, pSlvErr=1, no pop. All other accesses pSlvErr=0.
- Baud: counter 0..DIV, uClk toggles on wrap; uClk period = 2·(DIV+1) pClk. "fall tick" = cycle uClk goes 1→0; "rise tick" = 0→1.
- Frame: start 0, DATA_W bits LSB first, even parity bit if par_en, stop 1.
- TX FSM IDLE→START→DATA→(PARITY)→STOP→IDLE. Rx changes only on fall ticks. Leaves IDLE on a fall tick when tx_en=1 and TX FIFO non-empty (pop then). Back-to-back frames have no idle bit. tx_busy=1 outside IDLE.
- RX FSM IDLE→DATA→(PARITY)→STOP→IDLE, samples Tx on rise ticks only. Tx=0 sampled in IDLE with rx_en=1 starts a frame. In STOP: parity mismatch sets parity_err, Tx=0 sets frame_err; the word is pushed regardless. Push into full RX FIFO: word dropped, overrun set.
- Simultaneous APB pop and RX push on a full RX FIFO: both succeed, no overrun. Simultaneous APB push and TX pop on a full TX FIFO: both succeed, no error.
- Clearing tx_en/rx_en mid-frame: current frame completes, no new frame starts. DIV written mid-period: used from the next counter wrap. par_en sampled at frame start.

## Timing
- Reset values: pRData=0, pSlvErr=0, pReady=1, uClk=0, Rx=1, CTRL=0, DIV=0, STATUS sticky bits 0, FIFOs empty, FSMs IDLE, baud counter 0.
- Reset asserted mid-frame aborts immediately; Rx returns to 1 asynchronously.
- pRData/pSlvErr combinational from address and FIFO/register state during the access phase.
- STATUS reflects a push/pop on the pClk edge after it.
- TX latency: DATA write to start bit on Rx ≤ one uClk period plus one pClk when idle.
- RX latency: rx_empty clears one pClk after the rise tick that sampled the stop bit.

## Structure
- Shared package usrt_pkg: register address constants, STATUS/CTRL bit indices, and the TX/RX FSM state encodings.
- One sub-module: usrt_fifo (synchronous FIFO, parameters WIDTH and DEPTH, full/empty flags, push/pop ports), instantiated twice.
- Baud generator, TX FSM, RX FSM and register file live in apb_usrt_ctrl.

## Test plan
- Reset: check reset values; write CTRL=0x01, DIV=1, DATA=0xA5 -> Rx shows 0,1,0,1,0,0,1,0,1,1 on fall ticks; frame lasts 40 pClk.
- par_en=1, send 0x07 -> parity bit 1; frame of 11 bits = 44 pClk at DIV=1.
- Loop Rx to Tx, CTRL=0x07, write 0x3C -> RX read returns 0x3C, STATUS error bits 0.
- Fill TX FIFO with FIFO_DEPTH+1 writes while tx_en=0 -> last write pSlvErr=1; enable -> exactly FIFO_DEPTH frames sent.
- Inject 5 frames into Tx with no reads (depth 4) -> overrun=1, first 4 words readable; write 0x10 to STATUS -> overrun=0.
- Inject bad parity and a 0 stop bit -> parity_err and frame_err set; read DATA on empty FIFO -> 0x00, pSlvErr=1.
